// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on unsigned magnitudes.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_in_a,
   input  logic [WIDTH-1:0] i_in_b,
   input  logic             i_write_hi,
   input  logic             i_write_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t           r_state, w_state_nx;
   logic             r_is_div, w_is_div_nx;
   logic             r_sign_a, w_sign_a_nx;
   logic             r_neg, w_neg_nx;
   logic             r_b_zero, w_b_zero_nx;
   logic [WIDTH-1:0] r_opnd, w_opnd_nx;
   logic [WIDTH-1:0] r_acc, w_acc_nx;
   logic [WIDTH-1:0] r_q, w_q_nx;
   logic [CW-1:0]    r_cnt, w_cnt_nx;
   logic             r_busy, w_busy_nx;
   logic             r_done, w_done_nx;
   logic             r_dbz, w_dbz_nx;
   logic [WIDTH-1:0] r_hi, w_hi_nx;
   logic [WIDTH-1:0] r_lo, w_lo_nx;

   logic             w_sign_a, w_sign_b;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;
   logic [WIDTH-1:0] w_mul_addend;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_trial;
   logic [PW-1:0]    w_prod, w_prod_fix;
   logic [WIDTH-1:0] w_quo, w_rem;

   // Operand conditioning: signs only matter for MULT/DIV (op[0]==0)
   assign w_sign_a = ~i_op[0] & i_in_a[WIDTH-1];
   assign w_sign_b = ~i_op[0] & i_in_b[WIDTH-1];
   assign w_abs_a  = w_sign_a ? (WIDTH'(0) - i_in_a) : i_in_a;
   assign w_abs_b  = w_sign_b ? (WIDTH'(0) - i_in_b) : i_in_b;

   // Datapath steps; {r_acc,r_q} is the product/partial-remainder pair
   assign w_mul_addend = r_q[0] ? r_opnd : '0;
   assign w_mul_sum    = {1'b0, r_acc} + {1'b0, w_mul_addend};
   assign w_div_trial  = {r_acc, r_q[WIDTH-1]} - {1'b0, r_opnd};

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg ? (PW'(0) - w_prod) : w_prod;
   assign w_quo      = r_neg ? (WIDTH'(0) - r_q) : r_q;
   assign w_rem      = r_sign_a ? (WIDTH'(0) - r_acc) : r_acc;

   always_comb begin
      w_state_nx  = r_state;
      w_is_div_nx = r_is_div;
      w_sign_a_nx = r_sign_a;
      w_neg_nx    = r_neg;
      w_b_zero_nx = r_b_zero;
      w_opnd_nx   = r_opnd;
      w_acc_nx    = r_acc;
      w_q_nx      = r_q;
      w_cnt_nx    = r_cnt;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;
      w_dbz_nx    = 1'b0;
      w_hi_nx     = r_hi;
      w_lo_nx     = r_lo;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nx  = S_RUN;
               w_is_div_nx = i_op[1];
               w_sign_a_nx = w_sign_a;
               w_neg_nx    = w_sign_a ^ w_sign_b;
               w_b_zero_nx = (i_in_b == '0);
               w_opnd_nx   = w_abs_b;
               w_q_nx      = w_abs_a;
               w_acc_nx    = '0;
               w_cnt_nx    = '0;
               w_busy_nx   = 1'b1;
            end else begin
               if (i_write_hi) w_hi_nx = i_in_a;
               if (i_write_lo) w_lo_nx = i_in_a;
            end
         end
         S_RUN: begin
            if (r_is_div) begin
               if (!w_div_trial[WIDTH]) begin
                  w_acc_nx = w_div_trial[WIDTH-1:0];
                  w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
               end else begin
                  w_acc_nx = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                  w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               w_acc_nx = w_mul_sum[WIDTH:1];
               w_q_nx   = {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
            w_cnt_nx = r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) w_state_nx = S_FINISH;
         end
         S_FINISH: begin
            // Zero divisor leaves |A| in the remainder, so sign-fix restores raw inA
            if (r_is_div) begin
               w_hi_nx  = w_rem;
               w_lo_nx  = r_b_zero ? '1 : w_quo;
               w_dbz_nx = r_b_zero;
            end else begin
               {w_hi_nx, w_lo_nx} = w_prod_fix;
            end
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_neg    <= 1'b0;
         r_b_zero <= 1'b0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_is_div <= w_is_div_nx;
         r_sign_a <= w_sign_a_nx;
         r_neg    <= w_neg_nx;
         r_b_zero <= w_b_zero_nx;
         r_opnd   <= w_opnd_nx;
         r_acc    <= w_acc_nx;
         r_q      <= w_q_nx;
         r_cnt    <= w_cnt_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_dbz    <= w_dbz_nx;
         r_hi     <= w_hi_nx;
         r_lo     <= w_lo_nx;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_div_by_zero = r_dbz;
   assign o_hi          = r_hi;
   assign o_lo          = r_lo;

endmodule
